// File: rtl/space_invaders_pkg.sv
// Shared types and sizes for the invader game blocks (controller, player, sprite_drawer).
package space_invaders_pkg;

  localparam int NUM_COLS = 20;
  localparam int LINE_W   = 5;
  localparam int COL_W    = 5;
  localparam int ROW_W    = 4;
  localparam int STEP_W   = 24;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    WIN,
    LOSE
  } game_state_t;

  // RIGHT marches toward higher column index
  typedef enum logic {
    DIR_RIGHT,
    DIR_LEFT
  } march_dir_t;

  // Number of invaders still alive in the formation
  function automatic logic [COL_W-1:0] popcount_cols(input logic [NUM_COLS-1:0] cols);
    logic [COL_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      cnt = cnt + COL_W'(cols[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/invaders_step_timer.sv
// March prescaler: counts while run is high and emits a one-cycle tick every
// period cycles. The period is sampled only while idle or at a wrap so a
// change never truncates a step already in progress.
module invaders_step_timer
  import space_invaders_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [STEP_W-1:0] period,
  output logic              tick
);

  logic [STEP_W-1:0] count;
  logic [STEP_W-1:0] period_q;

  assign tick = run && (count == (period_q - STEP_W'(1)));

  // Counter held at zero while not running; wraps and re-latches period on tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      period_q <= '0;
    end else if (!run) begin
      count    <= '0;
      period_q <= period;
    end else if (tick) begin
      count    <= '0;
      period_q <= period;
    end else begin
      count    <= count + STEP_W'(1);
    end
  end

endmodule

// File: rtl/invaders_controller.sv
// Invader formation sequencer: owns the alive mask and formation line, marches
// the formation on the step tick, detects bullet hits and runs the game FSM.
// Optional feature macro SPEEDUP_EN: march period drops to STEP_DIV/4 once
// four or fewer invaders remain.
module invaders_controller
  import space_invaders_pkg::*;
#(
  parameter logic [NUM_COLS-1:0] INIT_ARRAY = 20'b00101010101010101010,
  parameter logic [LINE_W-1:0]   INIT_LINE  = 5'd2,
  parameter logic [LINE_W-1:0]   LOSE_LINE  = 5'd14,
  parameter logic [STEP_W-1:0]   STEP_DIV   = 24'd6_000_000
) (
  input  logic                clk_12MHz,
  input  logic                reset,
  input  logic                start_debounced,
  input  logic [COL_W-1:0]    bullet_x,
  input  logic [ROW_W-1:0]    bullet_y,
  input  logic                bullet_flying,
  output logic [NUM_COLS-1:0] invaders_array,
  output logic [LINE_W-1:0]   invaders_line,
  output logic                hit,
  output logic                clear,
  output logic                enable,
  output logic                game_over,
  output logic                win
);

  game_state_t         state;
  game_state_t         state_next;
  march_dir_t          dir;
  march_dir_t          next_dir;
  logic                hit_lock;
  logic                tick;
  logic                in_play;
  logic                new_game;
  logic                alive_at_x;
  logic                hit_now;
  logic [NUM_COLS-1:0] hit_mask;
  logic [NUM_COLS-1:0] post_hit;
  logic [NUM_COLS-1:0] next_array;
  logic [LINE_W-1:0]   next_line;
  logic [LINE_W-1:0]   line_down;
  logic [STEP_W-1:0]   period;

  assign in_play  = (state == PLAY);
  assign new_game = (state != PLAY) && start_debounced;

`ifdef SPEEDUP_EN
  assign period = (popcount_cols(invaders_array) <= COL_W'(4)) ? (STEP_DIV >> 2) : STEP_DIV;
`else
  assign period = STEP_DIV;
`endif

  invaders_step_timer u_step_timer (
    .clk    (clk_12MHz),
    .rst_n  (reset),
    .run    (in_play),
    .period (period),
    .tick   (tick)
  );

  // Game state transitions; an empty formation wins over reaching the ship row
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start_debounced) state_next = PLAY;
      PLAY: begin
        if (invaders_array == '0) begin
          state_next = WIN;
        end else if (invaders_line >= LOSE_LINE) begin
          state_next = LOSE;
        end
      end
      WIN, LOSE: if (start_debounced) state_next = PLAY;
      default: state_next = IDLE;
    endcase
  end

  // State register plus registered status outputs decoded from the next state
  always_ff @(posedge clk_12MHz or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      enable    <= 1'b0;
      game_over <= 1'b0;
      win       <= 1'b0;
    end else begin
      state     <= state_next;
      enable    <= (state_next == PLAY);
      game_over <= (state_next == LOSE);
      win       <= (state_next == WIN);
    end
  end

  // Hit detection, then march on tick applied to the already-hit formation
  always_comb begin
    alive_at_x = 1'b0;
    if (bullet_x < COL_W'(NUM_COLS)) begin
      alive_at_x = invaders_array[bullet_x];
    end
    hit_now = in_play && bullet_flying && !hit_lock &&
              (bullet_y == invaders_line[ROW_W-1:0]) && !invaders_line[LINE_W-1] &&
              alive_at_x;
    hit_mask   = hit_now ? (NUM_COLS'(1) << bullet_x) : '0;
    post_hit   = invaders_array & ~hit_mask;
    line_down  = (invaders_line == '1) ? invaders_line : invaders_line + LINE_W'(1);
    next_array = post_hit;
    next_line  = invaders_line;
    next_dir   = dir;
    if (tick) begin
      if (dir == DIR_RIGHT) begin
        if (post_hit[NUM_COLS-1]) begin
          next_line = line_down;
          next_dir  = DIR_LEFT;
        end else begin
          next_array = post_hit << 1;
        end
      end else begin
        if (post_hit[0]) begin
          next_line = line_down;
          next_dir  = DIR_RIGHT;
        end else begin
          next_array = post_hit >> 1;
        end
      end
    end
  end

  // Formation registers: reloaded on a new game, updated only while playing
  always_ff @(posedge clk_12MHz or negedge reset) begin
    if (!reset) begin
      invaders_array <= INIT_ARRAY;
      invaders_line  <= INIT_LINE;
      dir            <= DIR_RIGHT;
      hit_lock       <= 1'b0;
      hit            <= 1'b0;
      clear          <= 1'b0;
    end else if (new_game) begin
      invaders_array <= INIT_ARRAY;
      invaders_line  <= INIT_LINE;
      dir            <= DIR_RIGHT;
      hit_lock       <= 1'b0;
      hit            <= 1'b0;
      clear          <= 1'b1;
    end else begin
      clear <= 1'b0;
      hit   <= hit_now;
      if (in_play) begin
        invaders_array <= next_array;
        invaders_line  <= next_line;
        dir            <= next_dir;
        if (hit_now) begin
          hit_lock <= 1'b1;
        end else if (!bullet_flying) begin
          hit_lock <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_invaders_controller.sv
// Scoreboard bench for invaders_controller with a short march period.
module tb_invaders_controller;

  typedef enum int {EV_CLEAR, EV_HIT, EV_WIN, EV_LOSE} ev_kind_t;

  typedef struct {
    ev_kind_t    kind;
    logic [19:0] arr;
    logic [4:0]  line;
  } ev_t;

  localparam logic [19:0] INIT = 20'h2AAAA;

  logic        clk;
  logic        reset;
  logic        start;
  logic [4:0]  bx;
  logic [3:0]  by;
  logic        fly;
  logic [19:0] invaders_array;
  logic [4:0]  invaders_line;
  logic        hit;
  logic        clear;
  logic        enable;
  logic        game_over;
  logic        win;

  int  tests_run    = 0;
  int  tests_failed = 0;
  ev_t exp_q[$];
  logic win_q  = 1'b0;
  logic lose_q = 1'b0;

  invaders_controller #(
    .STEP_DIV (24'd8)
  ) dut (
    .clk_12MHz       (clk),
    .reset           (reset),
    .start_debounced (start),
    .bullet_x        (bx),
    .bullet_y        (by),
    .bullet_flying   (fly),
    .invaders_array  (invaders_array),
    .invaders_line   (invaders_line),
    .hit             (hit),
    .clear           (clear),
    .enable          (enable),
    .game_over       (game_over),
    .win             (win)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic f, input logic [4:0] x, input logic [3:0] y);
    fly = f;
    bx  = x;
    by  = y;
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_event(input ev_kind_t k, input logic [19:0] a, input logic [4:0] l);
    ev_t e;
    e.kind = k;
    e.arr  = a;
    e.line = l;
    exp_q.push_back(e);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    wait_edges(1);
    start = 1'b0;
  endtask

  // One bullet aimed at line 2: hit lands on the next edge, then the bullet retires
  task automatic do_hit(input logic [4:0] x, input logic [19:0] arr_after);
    applyStimulus(1'b1, x, 4'd2);
    expect_event(EV_HIT, arr_after, 5'd2);
    wait_edges(1);
    applyStimulus(1'b0, x, 4'd2);
    wait_edges(1);
  endtask

  task automatic check_event(input ev_kind_t got);
    ev_t e;
    if (exp_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL unexpected_event: got %s, expected none", got.name());
    end else begin
      e = exp_q.pop_front();
      checkOutput($sformatf("event_kind_%s", e.kind.name()), got, e.kind);
      checkOutput($sformatf("event_array_%s", e.kind.name()), invaders_array, e.arr);
      checkOutput($sformatf("event_line_%s", e.kind.name()), invaders_line, e.line);
    end
  endtask

  // Monitor: every pulse or status rise the DUT presents is matched against the queue
  always @(negedge clk) begin
    if (clear) check_event(EV_CLEAR);
    if (hit) check_event(EV_HIT);
    if (win && !win_q) check_event(EV_WIN);
    if (game_over && !lose_q) check_event(EV_LOSE);
    win_q  = win;
    lose_q = game_over;
  end

  initial begin
    #100000;
    tests_failed++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    applyStimulus(1'b0, 5'd0, 4'd0);
    wait_edges(3);
    checkOutput("rst_array", invaders_array, INIT);
    checkOutput("rst_line", invaders_line, 5'd2);
    checkOutput("rst_hit", hit, 1'b0);
    checkOutput("rst_clear", clear, 1'b0);
    checkOutput("rst_enable", enable, 1'b0);
    checkOutput("rst_game_over", game_over, 1'b0);
    checkOutput("rst_win", win, 1'b0);
    reset = 1'b1;
    wait_edges(1);

    // Game A: start, one march step, then asynchronous reset mid-play
    expect_event(EV_CLEAR, INIT, 5'd2);
    pulse_start();
    checkOutput("a_enable", enable, 1'b1);
    wait_edges(9);
    checkOutput("a_first_step", invaders_array, 20'h55554);
    reset = 1'b0;
    #1;
    checkOutput("midrst_array", invaders_array, INIT);
    checkOutput("midrst_line", invaders_line, 5'd2);
    checkOutput("midrst_enable", enable, 1'b0);
    checkOutput("midrst_hit", hit, 1'b0);
    checkOutput("midrst_clear", clear, 1'b0);
    wait_edges(2);
    reset = 1'b1;
    wait_edges(1);

    // Game B: single hit per bullet, lock release, march, hit on edge at tick
    expect_event(EV_CLEAR, INIT, 5'd2);
    pulse_start();
    checkOutput("b_enable", enable, 1'b1);
    applyStimulus(1'b1, 5'd3, 4'd2);
    expect_event(EV_HIT, 20'h2AAA2, 5'd2);
    wait_edges(3);
    applyStimulus(1'b1, 5'd5, 4'd2);
    wait_edges(2);
    checkOutput("lock_array", invaders_array, 20'h2AAA2);
    applyStimulus(1'b0, 5'd5, 4'd2);
    wait_edges(1);
    applyStimulus(1'b1, 5'd5, 4'd2);
    expect_event(EV_HIT, 20'h2AA82, 5'd2);
    wait_edges(1);
    applyStimulus(1'b0, 5'd5, 4'd2);
    wait_edges(1);
    checkOutput("b_step1_array", invaders_array, 20'h55504);
    checkOutput("b_step1_line", invaders_line, 5'd2);
    wait_edges(8);
    checkOutput("b_step2_array", invaders_array, 20'hAAA08);
    wait_edges(7);
    applyStimulus(1'b1, 5'd19, 4'd2);
    expect_event(EV_HIT, 20'h55410, 5'd2);
    wait_edges(1);
    checkOutput("edge_hit_array", invaders_array, 20'h55410);
    checkOutput("edge_hit_line", invaders_line, 5'd2);
    applyStimulus(1'b0, 5'd19, 4'd2);
    wait_edges(1);

`ifndef SPEEDUP_EN
    // Clear the rest of the formation around the next march step
    do_hit(5'd18, 20'h15410);
    do_hit(5'd16, 20'h05410);
    do_hit(5'd14, 20'h01410);
    wait_edges(2);
    checkOutput("b_step4_array", invaders_array, 20'h02820);
    do_hit(5'd13, 20'h00820);
    do_hit(5'd11, 20'h00020);
    do_hit(5'd5, 20'h00000);
    expect_event(EV_WIN, 20'h00000, 5'd2);
    checkOutput("win_flag", win, 1'b1);
    checkOutput("win_enable", enable, 1'b0);

    // Game C: restart from WIN, march down to the ship row
    expect_event(EV_CLEAR, INIT, 5'd2);
    pulse_start();
    checkOutput("c_enable", enable, 1'b1);
    checkOutput("c_win_clear", win, 1'b0);
    wait_edges(16);
    checkOutput("c_step2_array", invaders_array, 20'hAAAA8);
    checkOutput("c_step2_line", invaders_line, 5'd2);
    wait_edges(8);
    checkOutput("c_descend_array", invaders_array, 20'hAAAA8);
    checkOutput("c_descend_line", invaders_line, 5'd3);
    wait_edges(8);
    checkOutput("c_left_array", invaders_array, 20'h55554);
    checkOutput("c_left_line", invaders_line, 5'd3);
    wait_edges(68);
    pulse_start();
    expect_event(EV_LOSE, 20'h15555, 5'd14);
    wait_edges(276);
    checkOutput("lose_flag", game_over, 1'b1);
    checkOutput("lose_enable", enable, 1'b0);
    checkOutput("lose_line", invaders_line, 5'd14);
    wait_edges(8);
    checkOutput("lose_frozen_array", invaders_array, 20'h15555);
    checkOutput("lose_frozen_line", invaders_line, 5'd14);
    expect_event(EV_CLEAR, INIT, 5'd2);
    pulse_start();
    checkOutput("d_array", invaders_array, INIT);
    checkOutput("d_line", invaders_line, 5'd2);
    checkOutput("d_game_over", game_over, 1'b0);
`else
    // Down to four invaders: the period shortens from the next wrap onward
    do_hit(5'd18, 20'h15410);
    do_hit(5'd16, 20'h05410);
    wait_edges(4);
    checkOutput("fast_step_a", invaders_array, 20'h0A820);
    wait_edges(1);
    checkOutput("fast_step_b", invaders_array, 20'h15040);
    wait_edges(1);
    checkOutput("fast_hold", invaders_array, 20'h15040);
    wait_edges(1);
    checkOutput("fast_step_c", invaders_array, 20'h2A080);
`endif

    wait_edges(2);
    checkOutput("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
